// File: rtl/io_out_ctrl.sv
// IO output controller: memory-mapped LED register plus a multiplexed 8-digit seven-segment display.
// Optional SEG_BLANK_EN blanks digits above the most-significant nonzero nibble.
module io_out_ctrl #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter logic [13:0] LED_ADDR = 14'h3c60,
    parameter logic [13:0] SEG_ADDR = 14'h3c00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ioWrite_i,
    input  logic [13:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [15:0] led_o,
    output logic [7:0]  seg_en_o,
    output logic [7:0]  seg_o
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [15:0]      led_q,     led_d;
    logic [31:0]      seg_reg_q, seg_reg_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [7:0]       seg_en_q,  seg_en_d;
    logic [7:0]       seg_out_q, seg_out_d;
    logic [3:0]       nibble;
    logic             blank;

    function automatic logic [7:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 8'hC0;
            4'h1: hex_decode = 8'hF9;
            4'h2: hex_decode = 8'hA4;
            4'h3: hex_decode = 8'hB0;
            4'h4: hex_decode = 8'h99;
            4'h5: hex_decode = 8'h92;
            4'h6: hex_decode = 8'h82;
            4'h7: hex_decode = 8'hF8;
            4'h8: hex_decode = 8'h80;
            4'h9: hex_decode = 8'h90;
            4'hA: hex_decode = 8'h88;
            4'hB: hex_decode = 8'h83;
            4'hC: hex_decode = 8'hC6;
            4'hD: hex_decode = 8'hA1;
            4'hE: hex_decode = 8'h86;
            default: hex_decode = 8'h8E;
        endcase
    endfunction

    assign nibble = seg_reg_q[{idx_q, 2'b00} +: 4];

`ifdef SEG_BLANK_EN
    logic [2:0] top_idx;

    // Digit 0 is never blanked, so the search starts at 1 and defaults to 0.
    always_comb begin
        top_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (seg_reg_q[4*i +: 4] != 4'h0) top_idx = 3'(i);
        end
    end

    assign blank = (idx_q > top_idx);
`else
    assign blank = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        led_d     = led_q;
        seg_reg_d = seg_reg_q;
        cnt_d     = cnt_q + 1'b1;
        idx_d     = idx_q;

        if (ioWrite_i && addr_i == LED_ADDR) led_d     = write_data_i[15:0];
        if (ioWrite_i && addr_i == SEG_ADDR) seg_reg_d = write_data_i;

        if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end

        // Built from the current index and register, so a same-cycle write shows on the next update.
        seg_en_d  = ~(8'b1 << idx_q);
        seg_out_d = blank ? 8'hFF : hex_decode(nibble);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            led_q     <= '0;
            seg_reg_q <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            seg_en_q  <= 8'hFF;
            seg_out_q <= 8'hFF;
        end else begin
            led_q     <= led_d;
            seg_reg_q <= seg_reg_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            seg_en_q  <= seg_en_d;
            seg_out_q <= seg_out_d;
        end
    end

    assign led_o    = led_q;
    assign seg_en_o = seg_en_q;
    assign seg_o    = seg_out_q;

endmodule

// File: doc/io_out_ctrl.md
IO_OUT_CTRL -- requirements
Module: io_out_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles each seven-segment digit is driven (legal range 2..2^24).
REQ-002 SHALL have parameter LED_ADDR, default 14'h3c60, meaning the IO address of the LED register.
REQ-003 SHALL have parameter SEG_ADDR, default 14'h3c00, meaning the IO address of the seven-segment data register.
REQ-004 SHALL have port clk, input, 1, meaning the single system clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; synchronous, active-high (asserted = 1).
REQ-006 SHALL have port ioWrite_i, input, 1, meaning IO write strobe from the memory/IO select stage.
REQ-007 SHALL have port addr_i, input, 14, meaning IO address from the memory/IO select stage.
REQ-008 SHALL have port write_data_i, input, 32, meaning IO write data from the memory/IO select stage.
REQ-009 SHALL have port led_o, output, 16, meaning the LED drive, active-high.
REQ-010 SHALL have port seg_en_o, output, 8, meaning the digit enables, active-low, one-hot-low.
REQ-011 SHALL have port seg_o, output, 8, meaning the segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-012 SHALL load write_data_i[15:0] into the LED register at the edge where ioWrite_i=1 and addr_i==LED_ADDR; led_o SHALL show the new value from the following cycle.
REQ-013 SHALL load all 32 bits of write_data_i into the seg register at the edge where ioWrite_i=1 and addr_i==SEG_ADDR.
REQ-014 SHALL ignore writes to any other address, and ignore addr_i whenever ioWrite_i=0.
REQ-015 SHALL run a scan counter 0..SCAN_DIV-1. At terminal count the counter SHALL wrap to 0 and the digit index (0..7) SHALL increment, wrapping 7->0.
REQ-016 SHALL register seg_en_o and seg_o, updating them every cycle from the current index and seg register, one cycle of latency.
REQ-017 SHALL set seg_en_o = ~(8'b1 << index). Digit index i SHALL show nibble seg_reg[4i+3:4i].
REQ-018 SHALL hex-decode each nibble with dp off: 0..F -> C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E.
REQ-019 SHALL resolve simultaneous events as follows: a seg write and an index change in the same cycle use the old register value for that cycle's output update and the new value from the next update. The scan SHALL never stall on writes.
REQ-020 SHALL give a write the same priority when it coincides with any counter state; there is no busy or back-pressure.

Reset
REQ-021 SHALL clear, while rst_n=1 at an edge: LED register, seg register, scan counter and index to 0; led_o=16'h0000, seg_en_o=8'hFF, seg_o=8'hFF.
REQ-022 SHALL, with reset asserted mid-scan, abandon the current digit. The first cycle after release SHALL output index 0 (seg_en_o=8'hFE, seg_o=8'hC0).
REQ-023 SHALL give reset priority over a simultaneous write; the write is lost.

Configuration
REQ-024 SHALL provide macro SEG_BLANK_EN. When defined, digits above the most-significant nonzero nibble SHALL output seg_o=8'hFF with their enable still asserted, and digit 0 SHALL always be shown. When undefined, all eight digits SHALL be decoded per REQ-018.

Verification
REQ-025 SHALL cover LED write: ioWrite_i=1, addr 3c60, data 32'hABCD1234 -> led_o=16'h1234 the next cycle; seg register unchanged.
REQ-026 SHALL cover seg write and scan with SCAN_DIV=4: write 32'h76543210 to 3c00 -> seg_en_o steps FE,FD,FB,..,7F every 4 cycles; seg_o C0,F9,A4,B0,99,92,82,F8; wrap back to FE.
REQ-027 SHALL cover stray access: ioWrite_i=0 with addr 3c60, then ioWrite_i=1 with addr 3c20 -> led_o and seg register unchanged.
REQ-028 SHALL cover mid-scan reset: reset at index 5 -> outputs FF/FF during reset, then FE/C0 with registers 0.
REQ-029 SHALL cover blanking with SEG_BLANK_EN: seg register 32'h0000_00A0 -> digits 0,1 show C0,88; digits 2..7 show FF. Without the macro, digits 2..7 show C0.
REQ-030 SHALL cover the same-cycle case: a seg write at the scan terminal count -> the first update shows the old nibble and the next update shows the new one.
